stream_rr_arbiter: RTL

//  Shares one registered valid/ready output stage among NUM_REQ upstream streams.

---
 rtl/stream_arb_pkg.sv | 13 +
 rtl/stream_rr_arbiter_if.sv | 30 +++
 rtl/rr_pick.sv | 33 +++
 rtl/stream_rr_arbiter.sv | 86 ++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared helpers for the round-robin stream arbiter.
// Provides rr_next(): modulo increment of the round-robin pointer.
package stream_arb_pkg;

    // Wraps at n, so non-power-of-2 requester counts work.
    function automatic int unsigned rr_next(
        input int unsigned ptr,
        input int unsigned n
    );
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of the arbiter's upstream request streams and downstream output.
// Ports: req_data_i/req_last_i/req_valid_i/req_ready_o (per requester),
//        data_out/data_out_last/data_out_id/data_out_valid/data_out_ready.
interface stream_rr_arbiter_if #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0][WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [WIDTH-1:0]              data_out;
    logic                          data_out_last;
    logic [IDW-1:0]                data_out_id;
    logic                          data_out_valid;
    logic                          data_out_ready;

    modport master (
        output req_data_i, req_last_i, req_valid_i, data_out_ready,
        input  req_ready_o, data_out, data_out_last, data_out_id,
        input  data_out_valid
    );

    modport slave (
        input  req_data_i, req_last_i, req_valid_i, data_out_ready,
        output req_ready_o, data_out, data_out_last, data_out_id,
        output data_out_valid
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr.
// Ports: i_req (request vector), i_ptr (start index),
//        o_idx (winner index), o_any (some request is set).
module rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);
    logic [2*N-1:0] w_masked;
    logic           w_found;

    // Doubling the vector turns the wrap-around search into a plain
    // lowest-set-bit search over positions ptr .. 2N-1.
    always_comb begin
        w_masked = {i_req, i_req};
        for (int i = 0; i < 2 * N; i++) begin
            if (i < 32'(i_ptr)) w_masked[i] = 1'b0;
        end
        o_any   = |i_req;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!w_found && w_masked[i]) begin
                w_found = 1'b1;
                o_idx   = IDW'(i % N);
            end
        end
    end
endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready stage among
// NUM_REQ streams, with optional packet lock until last.
// Ports: clk_i, arst_n (sync, active-low), bus (slave side of stream_rr_arbiter_if).
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int WIDTH        = 8,
    parameter  int LOCK_ON_LAST = 1,
    localparam int IDW          = $clog2(NUM_REQ)
) (
    input  logic                clk_i,
    input  logic                arst_n,
    stream_rr_arbiter_if.slave  bus
);
    logic [IDW-1:0]     r_rr_ptr;
    logic               r_locked;
    logic [IDW-1:0]     r_lock_id;
    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic               r_last;
    logic [IDW-1:0]     r_id;

    logic [IDW-1:0]     w_pick_idx;
    logic               w_pick_any;
    logic [IDW-1:0]     w_winner;
    logic               w_stage_ready;
    logic               w_grant;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_ready;
    logic [IDW-1:0]     w_ptr_next;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .i_req (bus.req_valid_i),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // A locked grant is held even while its requester is idle.
    always_comb begin
        w_stage_ready = !r_valid | bus.data_out_ready;
        w_winner      = r_locked ? r_lock_id : w_pick_idx;
        w_grant       = (r_locked | w_pick_any) & w_stage_ready & arst_n;
        w_ready       = '0;
        if (w_grant) w_ready[w_winner] = 1'b1;
        w_accept      = w_grant & bus.req_valid_i[w_winner];
        w_ptr_next    = IDW'(rr_next(32'(w_winner), NUM_REQ));
    end

    always_ff @(posedge clk_i) begin
        if (!arst_n) begin
            r_valid   <= 1'b0;
            r_rr_ptr  <= '0;
            r_locked  <= 1'b0;
            r_lock_id <= '0;
        end else begin
            if (w_accept)                r_valid <= 1'b1;
            else if (bus.data_out_ready) r_valid <= 1'b0;
            if (w_accept) begin
                if (LOCK_ON_LAST != 0 && !bus.req_last_i[w_winner]) begin
                    r_locked  <= 1'b1;
                    r_lock_id <= w_winner;
                end else begin
                    r_locked  <= 1'b0;
                    r_rr_ptr  <= w_ptr_next;
                end
            end
        end
    end

    // Payload needs no reset; it is qualified by r_valid.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_data <= bus.req_data_i[w_winner];
            r_last <= bus.req_last_i[w_winner];
            r_id   <= w_winner;
        end
    end

    assign bus.req_ready_o    = w_ready;
    assign bus.data_out       = r_data;
    assign bus.data_out_last  = r_last;
    assign bus.data_out_id    = r_id;
    assign bus.data_out_valid = r_valid;
endmodule
